// File: rtl/hamming_uart_receiver.sv
// Receive side of the Hamming-protected RS-232 link: 8N1 deserialiser,
// high/low frame pairing with timeout, and per-frame SECDED nibble decode.
`timescale 1ns/1ps

module hamming_uart_receiver #(
    parameter logic [31:0] FREQUENCY    = 32'd50_000_000,
    parameter logic [31:0] SPEED        = 32'd9600,
    parameter logic [31:0] TIMEOUT_BITS = 32'd30
) (
    input  logic       CLK_i,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       corrected_o,
    output logic       uncorrectable_o,
    output logic       frame_err_o,
    output logic       timeout_o,
    output logic       busy_o
);

    localparam logic [31:0] DIV      = FREQUENCY / SPEED;
    localparam logic [31:0] HALF     = DIV / 32'd2;
    localparam logic [31:0] TMO_LOAD = TIMEOUT_BITS * DIV;

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_e;
    typedef enum logic       {P_HI_WAIT, P_LO_WAIT}             pair_e;

    // Returns {uncorrectable, corrected, nibble[3:0]} for one received frame.
    function automatic logic [5:0] decode_frame(input logic [7:0] f);
        logic [2:0] s;
        logic       q;
        logic [7:0] c;
        s[0] = f[0] ^ f[2] ^ f[4] ^ f[6];
        s[1] = f[1] ^ f[2] ^ f[5] ^ f[6];
        s[2] = f[3] ^ f[4] ^ f[5] ^ f[6];
        q    = ^f;
        c    = f;
        if (q && (s != 3'd0)) begin
            c[s - 3'd1] = ~c[s - 3'd1];
        end
        return {(s != 3'd0) && !q, q, c[6], c[5], c[4], c[2]};
    endfunction

    logic        sync1_q, sync2_q, prev_q;
    logic        rx_s, fall;

    uart_e       uart_q, uart_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        armed_q, armed_d;
    logic        byte_done, ferr;

    pair_e       pair_q, pair_d;
    logic [7:0]  hi_q, hi_d;
    logic [31:0] tmo_q, tmo_d;
    logic        decode_en, tmo_pulse;
    logic [5:0]  hi_dec, lo_dec;

    logic [7:0]  data_q;
    logic        valid_q, corr_q, unc_q, ferr_q, tout_q;

    // Two-flop synchroniser plus one delay flop for falling-edge detection.
    always_ff @(posedge CLK_i or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rx_s = sync2_q;
    assign fall = prev_q & ~sync2_q;

    // UART state register, baud counter, bit counter and shift register.
    always_ff @(posedge CLK_i or negedge reset_n) begin
        if (!reset_n) begin
            uart_q  <= U_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
        end else begin
            uart_q  <= uart_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
        end
    end

    // UART next-state: mid-bit sampling, LSB first, stop-bit check.
    always_comb begin
        uart_d    = uart_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        armed_d   = armed_q;
        byte_done = 1'b0;
        ferr      = 1'b0;
        case (uart_q)
            U_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!armed_q) begin
                    armed_d = rx_s;
                end else if (fall) begin
                    uart_d = U_START;
                end
            end
            U_START: begin
                if (cnt_q == HALF - 32'd1) begin
                    cnt_d  = '0;
                    uart_d = rx_s ? U_IDLE : U_DATA;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            U_DATA: begin
                if (cnt_q == DIV - 32'd1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        uart_d = U_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            U_STOP: begin
                if (cnt_q == DIV - 32'd1) begin
                    cnt_d  = '0;
                    uart_d = U_IDLE;
                    if (rx_s) begin
                        byte_done = 1'b1;
                    end else begin
                        ferr    = 1'b1;
                        armed_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: uart_d = U_IDLE;
        endcase
    end

    // Pairing state register, held high frame and timeout counter.
    always_ff @(posedge CLK_i or negedge reset_n) begin
        if (!reset_n) begin
            pair_q <= P_HI_WAIT;
            hi_q   <= '0;
            tmo_q  <= '0;
        end else begin
            pair_q <= pair_d;
            hi_q   <= hi_d;
            tmo_q  <= tmo_d;
        end
    end

    // Pairing next-state: a byte completing on the expiry cycle wins over timeout.
    always_comb begin
        pair_d    = pair_q;
        hi_d      = hi_q;
        tmo_d     = tmo_q;
        decode_en = 1'b0;
        tmo_pulse = 1'b0;
        if (ferr) begin
            pair_d = P_HI_WAIT;
            tmo_d  = '0;
        end else begin
            case (pair_q)
                P_HI_WAIT: begin
                    if (byte_done) begin
                        hi_d   = shift_q;
                        tmo_d  = TMO_LOAD;
                        pair_d = P_LO_WAIT;
                    end
                end
                P_LO_WAIT: begin
                    if (byte_done) begin
                        decode_en = 1'b1;
                        tmo_d     = '0;
                        pair_d    = P_HI_WAIT;
                    end else if (tmo_q == 32'd0) begin
                        tmo_pulse = 1'b1;
                        pair_d    = P_HI_WAIT;
                    end else begin
                        tmo_d = tmo_q - 32'd1;
                    end
                end
                default: pair_d = P_HI_WAIT;
            endcase
        end
    end

    // Per-frame SECDED decode; the low frame is still in the shift register.
    always_comb begin
        hi_dec = decode_frame(hi_q);
        lo_dec = decode_frame(shift_q);
    end

    // Registered outputs: data and flags update together with valid.
    always_ff @(posedge CLK_i or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            corr_q  <= 1'b0;
            unc_q   <= 1'b0;
            ferr_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            valid_q <= decode_en;
            ferr_q  <= ferr;
            tout_q  <= tmo_pulse;
            if (decode_en) begin
                data_q <= {hi_dec[3:0], lo_dec[3:0]};
                corr_q <= hi_dec[4] | lo_dec[4];
                unc_q  <= hi_dec[5] | lo_dec[5];
            end
        end
    end

    assign data_o          = data_q;
    assign valid_o         = valid_q;
    assign corrected_o     = corr_q;
    assign uncorrectable_o = unc_q;
    assign frame_err_o     = ferr_q;
    assign timeout_o       = tout_q;
    assign busy_o          = (uart_q != U_IDLE) || (pair_q == P_LO_WAIT);

endmodule

// File: tb/tb_hamming_uart_receiver.sv
// Bench for hamming_uart_receiver: vector table, randomized packages checked
// against a nearest-codeword reference model, and multi-cycle corner cases.
`timescale 1ns/1ps

module tb_hamming_uart_receiver;

    localparam int unsigned DIV = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_o;
    logic       valid_o, corrected_o, uncorrectable_o, frame_err_o, timeout_o, busy_o;

    int tests = 0;
    int failed = 0;

    int unsigned n_valid = 0;
    int unsigned n_tmo = 0;
    int unsigned n_ferr = 0;
    logic [7:0]  obs_data [64];
    logic        obs_corr [64];
    logic        obs_unc  [64];

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        int         gap;
        logic [7:0] data;
        logic       corr;
        logic       unc;
    } vec_t;

    vec_t vecs [5];

    hamming_uart_receiver #(
        .FREQUENCY   (32'd960000),
        .SPEED       (32'd9600),
        .TIMEOUT_BITS(32'd30)
    ) dut (
        .CLK_i          (clk),
        .reset_n        (rst_n),
        .rx             (rx),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .corrected_o    (corrected_o),
        .uncorrectable_o(uncorrectable_o),
        .frame_err_o    (frame_err_o),
        .timeout_o      (timeout_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    // Event monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (valid_o) begin
            obs_data[n_valid % 64] = data_o;
            obs_corr[n_valid % 64] = corrected_o;
            obs_unc[n_valid % 64]  = uncorrectable_o;
            n_valid++;
        end
        if (timeout_o) n_tmo++;
        if (frame_err_o) n_ferr++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference encoder straight from the parity equations.
    function automatic logic [7:0] enc(input logic [3:0] n);
        logic [7:0] f;
        f[2] = n[0];
        f[4] = n[1];
        f[5] = n[2];
        f[6] = n[3];
        f[0] = n[0] ^ n[1] ^ n[3];
        f[1] = n[0] ^ n[2] ^ n[3];
        f[3] = n[1] ^ n[2] ^ n[3];
        f[7] = ^f[6:0];
        return f;
    endfunction

    // Reference decoder: nearest valid codeword by Hamming distance.
    function automatic logic [5:0] model_dec(input logic [7:0] f);
        int         best_d = 9;
        logic [3:0] best_n = 4'd0;
        for (int n = 0; n < 16; n++) begin
            int d;
            d = $countones(f ^ enc(4'(n)));
            if (d < best_d) begin
                best_d = d;
                best_n = 4'(n);
            end
        end
        if (best_d == 0) return {2'b00, best_n};
        if (best_d == 1) return {2'b01, best_n};
        return {2'b10, f[6], f[5], f[4], f[2]};
    endfunction

    function automatic logic [7:0] rand_flips();
        logic [7:0] m = 8'h00;
        int k = int'($urandom_range(2, 0));
        for (int i = 0; i < k; i++) begin
            m = m ^ (8'h01 << $urandom_range(7, 0));
        end
        return m;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * DIV) @(negedge clk);
    endtask

    task automatic run_pair(input string name, input logic [7:0] hi, input logic [7:0] lo,
                            input int gap, input logic [7:0] ed, input logic ec, input logic eu);
        int unsigned v0, t0, f0;
        v0 = n_valid;
        t0 = n_tmo;
        f0 = n_ferr;
        send_byte(hi, 1'b1);
        check({name, "_busy_lo_wait"}, 32'(busy_o), 32'd1);
        if (gap > 0) idle_bits(gap);
        send_byte(lo, 1'b1);
        repeat (20) @(negedge clk);
        check({name, "_valid_count"}, n_valid - v0, 32'd1);
        if (n_valid > v0) begin
            check({name, "_data"}, 32'(obs_data[v0 % 64]), 32'(ed));
            check({name, "_flags"}, 32'({obs_corr[v0 % 64], obs_unc[v0 % 64]}), 32'({ec, eu}));
        end
        check({name, "_data_held"}, 32'(data_o), 32'(ed));
        check({name, "_no_tmo_ferr"}, (n_tmo - t0) + (n_ferr - f0), 32'd0);
        check({name, "_busy_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int unsigned v0, t0, f0;
        logic [7:0]  d, hi, lo;
        logic [5:0]  mh, ml;

        vecs[0] = '{8'hD2, 8'h2D, 0,  8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'hD2, 8'h3D, 0,  8'hA5, 1'b1, 1'b0};
        vecs[2] = '{8'h52, 8'h2D, 0,  8'hA5, 1'b1, 1'b0};
        vecs[3] = '{8'hD2, 8'h69, 0,  8'hAC, 1'b0, 1'b1};
        vecs[4] = '{8'hD2, 8'h2D, 19, 8'hA5, 1'b0, 1'b0};

        // Reset state
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(data_o), 32'd0);
        check("reset_flags", 32'({valid_o, corrected_o, uncorrectable_o, frame_err_o, timeout_o, busy_o}), 32'd0);
        rst_n = 1'b1;
        idle_bits(2);

        // Table vectors
        for (int i = 0; i < 5; i++) begin
            run_pair($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, vecs[i].gap,
                     vecs[i].data, vecs[i].corr, vecs[i].unc);
        end

        // Randomized packages against the reference model
        for (int i = 0; i < 12; i++) begin
            d  = 8'($urandom);
            hi = enc(d[7:4]) ^ rand_flips();
            lo = enc(d[3:0]) ^ rand_flips();
            mh = model_dec(hi);
            ml = model_dec(lo);
            run_pair($sformatf("rnd%0d", i), hi, lo, 0, {mh[3:0], ml[3:0]},
                     mh[4] | ml[4], mh[5] | ml[5]);
        end

        // Orphan high frame times out
        v0 = n_valid;
        t0 = n_tmo;
        send_byte(8'hD2, 1'b1);
        idle_bits(31);
        check("tmo_pulse", n_tmo - t0, 32'd1);
        check("tmo_no_valid", n_valid - v0, 32'd0);
        check("tmo_busy", 32'(busy_o), 32'd0);
        run_pair("after_tmo", 8'hD2, 8'h2D, 0, 8'hA5, 1'b0, 1'b0);

        // Frame error on an isolated frame
        v0 = n_valid;
        f0 = n_ferr;
        send_byte(8'hD2, 1'b0);
        idle_bits(2);
        check("ferr_pulse", n_ferr - f0, 32'd1);
        check("ferr_no_valid", n_valid - v0, 32'd0);
        check("ferr_busy", 32'(busy_o), 32'd0);
        run_pair("after_ferr", 8'hD2, 8'h2D, 0, 8'hA5, 1'b0, 1'b0);

        // Frame error on the low frame drops the held high frame
        v0 = n_valid;
        f0 = n_ferr;
        send_byte(8'hD2, 1'b1);
        send_byte(8'h2D, 1'b0);
        idle_bits(2);
        check("ferr_lo_pulse", n_ferr - f0, 32'd1);
        check("ferr_lo_no_valid", n_valid - v0, 32'd0);
        check("ferr_lo_busy", 32'(busy_o), 32'd0);
        run_pair("after_ferr_lo", 8'hD2, 8'h2D, 0, 8'hA5, 1'b0, 1'b0);

        // Short low glitch on idle line is a false start
        v0 = n_valid;
        f0 = n_ferr;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_start", 32'(busy_o), 32'd1);
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_busy_end", 32'(busy_o), 32'd0);
        check("glitch_no_events", (n_valid - v0) + (n_ferr - f0), 32'd0);

        // Asynchronous reset in the middle of the low frame
        run_pair("pre_reset", 8'hD2, 8'h3D, 0, 8'hA5, 1'b1, 1'b0);
        v0 = n_valid;
        send_byte(8'hD2, 1'b1);
        rx = 1'b0;
        repeat (350) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_data", 32'(data_o), 32'd0);
        check("midreset_flags", 32'({valid_o, corrected_o, uncorrectable_o, frame_err_o, timeout_o, busy_o}), 32'd0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(2);
        check("midreset_no_valid", n_valid - v0, 32'd0);
        check("midreset_data_after", 32'(data_o), 32'd0);
        run_pair("after_reset", 8'hD2, 8'h2D, 0, 8'hA5, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
